// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA mode timings, counter helpers and the delayed scan-state type
package vga_pkg;

    typedef enum logic [0:0] {
        MODE_640X480,
        MODE_800X600
    } vgaMode_t;

    typedef struct packed {
        int hActive;
        int hFp;
        int hSync;
        int hBp;
        int vActive;
        int vFp;
        int vSync;
        int vBp;
    } vgaTiming_t;

    // Scan state that travels alongside the pixel-source latency; all-zero reads as blank/idle.
    typedef struct packed {
        logic active;
        logic hsyncOn;
        logic vsyncOn;
        logic frameFirst;
    } scanBits_t;

    function automatic vgaTiming_t modeTiming(input vgaMode_t mode);
        vgaTiming_t t;
        case (mode)
            MODE_800X600: t = '{hActive: 800, hFp: 40, hSync: 128, hBp: 88,
                                vActive: 600, vFp: 1,  vSync: 4,   vBp: 23};
            default:      t = '{hActive: 640, hFp: 16, hSync: 96,  hBp: 48,
                                vActive: 480, vFp: 10, vSync: 2,   vBp: 33};
        endcase
        return t;
    endfunction

    localparam vgaTiming_t VGA_640X480 = modeTiming(MODE_640X480);

    function automatic int totalCount(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cntWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters and raw active/sync/frame-first decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480.hActive,
    parameter int H_FP     = VGA_640X480.hFp,
    parameter int H_SYNC   = VGA_640X480.hSync,
    parameter int H_BP     = VGA_640X480.hBp,
    parameter int V_ACTIVE = VGA_640X480.vActive,
    parameter int V_FP     = VGA_640X480.vFp,
    parameter int V_SYNC   = VGA_640X480.vSync,
    parameter int V_BP     = VGA_640X480.vBp,
    localparam int XW      = cntWidth(H_ACTIVE),
    localparam int YW      = cntWidth(V_ACTIVE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic [XW-1:0] hPos,
    output logic [YW-1:0] vPos,
    output scanBits_t     scan
);

    localparam int H_TOT    = totalCount(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT    = totalCount(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW       = cntWidth(H_TOT);
    localparam int VW       = cntWidth(V_TOT);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    logic          hWrap;
    logic          vWrap;

    assign hWrap = (32'(hCnt) == H_TOT - 1);
    assign vWrap = (32'(vCnt) == V_TOT - 1);

    // A stopped scan parks at (0,0) so re-enabling always starts a fresh frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (!enable) begin
            hCnt <= '0;
            vCnt <= '0;
        end else begin
            hCnt <= hWrap ? '0 : hCnt + 1'b1;
            if (hWrap) begin
                vCnt <= vWrap ? '0 : vCnt + 1'b1;
            end
        end
    end

    assign hPos = hCnt[XW-1:0];
    assign vPos = vCnt[YW-1:0];

    always_comb begin
        scan = '0;
        if (enable) begin
            scan.active     = (32'(hCnt) < H_ACTIVE) && (32'(vCnt) < V_ACTIVE);
            scan.hsyncOn    = (32'(hCnt) >= HS_START) && (32'(hCnt) < HS_END);
            scan.vsyncOn    = (32'(vCnt) >= VS_START) && (32'(vCnt) < VS_END);
            scan.frameFirst = (hCnt == '0) && (vCnt == '0);
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - VGA scan with pixel-source latency compensation and underflow detection
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480.hActive,
    parameter int H_FP     = VGA_640X480.hFp,
    parameter int H_SYNC   = VGA_640X480.hSync,
    parameter int H_BP     = VGA_640X480.hBp,
    parameter int V_ACTIVE = VGA_640X480.vActive,
    parameter int V_FP     = VGA_640X480.vFp,
    parameter int V_SYNC   = VGA_640X480.vSync,
    parameter int V_BP     = VGA_640X480.vBp,
    parameter int CW       = 3,
    parameter int PIPE_LAT = 2,
    parameter int SYNC_POL = 0,
    localparam int XW      = cntWidth(H_ACTIVE),
    localparam int YW      = cntWidth(V_ACTIVE),
    localparam int RGBW    = 3 * CW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    output logic            pix_req,
    output logic [XW-1:0]   pixel_x,
    output logic [YW-1:0]   pixel_y,
    input  logic [RGBW-1:0] rgb_in,
    input  logic            rgb_valid,
    output logic [RGBW-1:0] vga_rgb,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic            vga_blank,
    output logic            frame_start,
    output logic            underflow,
    input  logic            clr_underflow
);

    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic [XW-1:0] hPos;
    logic [YW-1:0] vPos;
    scanBits_t     scan;
    scanBits_t     stage [PIPE_LAT];
    scanBits_t     late;
    logic          dropEvent;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) timing (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .hPos   (hPos),
        .vPos   (vPos),
        .scan   (scan)
    );

    assign pix_req = scan.active & ~reset;
    assign pixel_x = pix_req ? hPos : '0;
    assign pixel_y = pix_req ? vPos : '0;

    // Sync levels are stored as "asserted" flags so a cleared pipeline reads as idle for either polarity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= scan;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign late      = stage[PIPE_LAT-1];
    assign dropEvent = late.active & ~rgb_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_rgb     <= '0;
            vga_hsync   <= ~SYNC_ON;
            vga_vsync   <= ~SYNC_ON;
            vga_blank   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= (late.active && rgb_valid) ? rgb_in : '0;
            vga_hsync   <= late.hsyncOn ? SYNC_ON : ~SYNC_ON;
            vga_vsync   <= late.vsyncOn ? SYNC_ON : ~SYNC_ON;
            vga_blank   <= ~late.active;
            frame_start <= late.frameFirst;
        end
    end

    // A fresh drop outranks a simultaneous clear so no missing pixel goes unreported.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (dropEvent) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end
    end

endmodule
